// File: rtl/rs_src_trk_pkg.sv
// Shared types for the reservation-station operand tracker: ROB ids,
// per-source static info, writeback port payload and the per-source FSM.
package rs_defs;

  localparam int unsigned ROB_ID_W   = 6;
  localparam int unsigned DESCR_W    = 4;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [ROB_ID_W-1:0]   t_rob_id;
  typedef logic [DESCR_W-1:0]    t_uopnd_descr;
  typedef logic [REG_DATA_W-1:0] t_rv_reg_data;

  typedef struct packed {
    logic         from_rob;
    t_rob_id      robid;
    t_uopnd_descr descr;
  } t_rs_src_static;

  typedef struct packed {
    t_rob_id      robid;
    t_rv_reg_data value;
  } t_wb_port;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PDG_ROB = 2'd1,
    READY   = 2'd2
  } t_src_fsm;

  // Full-width id compare; the ROB keeps live ids unique so no wrap logic.
  function automatic logic wb_hit(input logic vld, input t_wb_port wb, input t_rob_id id);
    return vld && (wb.robid == id);
  endfunction

endpackage

// File: rtl/rs_src_slot.sv
// One tracked operand: FSM, data register and the writeback match/mux.
// Event priority has already been decoded by the parent (mutually exclusive strobes).
module rs_src_slot
  import rs_defs::*;
#(
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     do_flush,
  input  logic                     do_alloc,
  input  logic                     do_dealloc,
  input  t_rs_src_static           alloc_static,
  input  logic [DATA_W-1:0]        regrd_data,
  input  t_rob_id                  wait_robid,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  t_wb_port [NUM_WB-1:0]    wb_result,
  output t_src_fsm                 state,
  output logic                     ready,
  output logic [DATA_W-1:0]        data
);

  t_rob_id      cmp_id_s;
  logic         hit_s;
  t_rv_reg_data hit_val_s;
  t_src_fsm     state_nxt_s;
  logic [DATA_W-1:0] data_nxt_s;

  // Writeback snoop: on alloc compare against the incoming id (bypass), else the held id; lowest port wins.
  always_comb begin
    cmp_id_s  = do_alloc ? alloc_static.robid : wait_robid;
    hit_s     = 1'b0;
    hit_val_s = {REG_DATA_W{1'b0}};
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (wb_hit(wb_valid[p], wb_result[p], cmp_id_s)) begin
        hit_s     = 1'b1;
        hit_val_s = wb_result[p].value;
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Next-state and next-data selection.
  always_comb begin
    state_nxt_s = state;
    data_nxt_s  = data;
    if (do_flush) begin
      state_nxt_s = EMPTY;
    end else if (do_alloc) begin
      if (!alloc_static.from_rob) begin
        state_nxt_s = READY;
        data_nxt_s  = regrd_data;
      end else if (hit_s) begin
        state_nxt_s = READY;
        data_nxt_s  = DATA_W'(hit_val_s);
      end else begin
        state_nxt_s = PDG_ROB;
      end
    end else if (do_dealloc) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state)
        PDG_ROB: begin
          if (hit_s) begin
            state_nxt_s = READY;
            data_nxt_s  = DATA_W'(hit_val_s);
          end else begin
            state_nxt_s = PDG_ROB;
          end
        end
        EMPTY:   state_nxt_s = EMPTY;
        READY:   state_nxt_s = READY;
        default: state_nxt_s = EMPTY;
      endcase
    end
  end

  // State, ready flag and operand registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      ready <= 1'b0;
      data  <= {DATA_W{1'b0}};
    end else begin
      state <= state_nxt_s;
      ready <= (state_nxt_s == READY);
      data  <= data_nxt_s;
    end
  end

endmodule

// File: rtl/rs_src_trk_chk.sv
// Protocol and state-legality checks for one reservation-station entry.
module rs_src_trk_chk
  import rs_defs::*;
#(
  parameter int unsigned NUM_SRCS = 2,
  parameter int unsigned NUM_WB   = 2
) (
  input logic                           clk,
  input logic                           reset,
  input logic                           flush,
  input logic                           alloc,
  input logic                           dealloc,
  input logic                           e_valid,
  input logic                           all_ready,
  input t_src_fsm       [NUM_SRCS-1:0]  src_state,
  input t_rs_src_static [NUM_SRCS-1:0]  e_static,
  input t_rs_src_static [NUM_SRCS-1:0]  alloc_static,
  input logic           [NUM_WB-1:0]    wb_valid,
  input t_wb_port       [NUM_WB-1:0]    wb_result
);

  function automatic int unsigned match_cnt(input logic [NUM_WB-1:0] v,
                                            input t_wb_port [NUM_WB-1:0] r,
                                            input t_rob_id id);
    int unsigned cnt;
    cnt = 32'd0;
    for (int p = 0; p < NUM_WB; p++) begin
      cnt += 32'(wb_hit(v[p], r[p], id));
    end
    return cnt;
  endfunction

  a_alloc_busy: assert property (@(posedge clk) disable iff (!reset)
    (alloc && !flush) |-> (!e_valid || dealloc));

  a_dealloc_ready: assert property (@(posedge clk) disable iff (!reset)
    (dealloc && !flush) |-> all_ready);

  for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
    a_state_legal: assert property (@(posedge clk) disable iff (!reset)
      src_state[s] inside {EMPTY, PDG_ROB, READY});

    a_wb_multi_alloc: assert property (@(posedge clk) disable iff (!reset)
      (alloc && !flush && alloc_static[s].from_rob)
        |-> (match_cnt(wb_valid, wb_result, alloc_static[s].robid) <= 32'd1));

    a_wb_multi_pdg: assert property (@(posedge clk) disable iff (!reset)
      (!alloc && !flush && src_state[s] == PDG_ROB)
        |-> (match_cnt(wb_valid, wb_result, e_static[s].robid) <= 32'd1));
  end

endmodule

// File: rtl/rs_src_trk.sv
// Reservation-station entry operand tracker: event priority decode, entry
// valid/static capture, and one rs_src_slot per source operand.
module rs_src_trk
  import rs_defs::*;
#(
  parameter int unsigned NUM_SRCS = 2,
  parameter int unsigned NUM_WB   = 2,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                e_alloc_rs0,
  input  t_rs_src_static [NUM_SRCS-1:0]       e_alloc_static_rs0,
  input  logic [NUM_SRCS-1:0][DATA_W-1:0]     regrd_data_rs0,
  input  logic                                e_dealloc_rs1,
  input  logic [NUM_WB-1:0]                   wb_valid_rb0,
  input  t_wb_port [NUM_WB-1:0]               wb_result_rb0,
  output logic                                e_valid,
  output t_rs_src_static [NUM_SRCS-1:0]       e_static,
  output logic [NUM_SRCS-1:0]                 src_ready_rs1,
  output logic                                all_ready_rs1,
  output logic [NUM_SRCS-1:0][DATA_W-1:0]     src_data
);

  logic do_alloc_s;
  logic do_dealloc_s;
  t_src_fsm [NUM_SRCS-1:0] slot_state_s;

  // flush > alloc > dealloc; writeback is handled inside each slot.
  assign do_alloc_s   = e_alloc_rs0 & ~flush;
  assign do_dealloc_s = e_dealloc_rs1 & ~e_alloc_rs0 & ~flush;

  // Entry valid flag and captured static operand info.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid  <= 1'b0;
      e_static <= {NUM_SRCS{{($bits(t_rs_src_static)){1'b0}}}};
    end else if (flush) begin
      e_valid  <= 1'b0;
    end else if (do_alloc_s) begin
      e_valid  <= 1'b1;
      e_static <= e_alloc_static_rs0;
    end else if (do_dealloc_s) begin
      e_valid  <= 1'b0;
    end else begin
      e_valid  <= e_valid;
    end
  end

  for (genvar s = 0; s < NUM_SRCS; s++) begin : g_slot
    rs_src_slot #(
      .NUM_WB (NUM_WB),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .do_flush     (flush),
      .do_alloc     (do_alloc_s),
      .do_dealloc   (do_dealloc_s),
      .alloc_static (e_alloc_static_rs0[s]),
      .regrd_data   (regrd_data_rs0[s]),
      .wait_robid   (e_static[s].robid),
      .wb_valid     (wb_valid_rb0),
      .wb_result    (wb_result_rb0),
      .state        (slot_state_s[s]),
      .ready        (src_ready_rs1[s]),
      .data         (src_data[s])
    );
  end

  assign all_ready_rs1 = e_valid & (&src_ready_rs1);

  rs_src_trk_chk #(
    .NUM_SRCS (NUM_SRCS),
    .NUM_WB   (NUM_WB)
  ) u_chk (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .alloc        (e_alloc_rs0),
    .dealloc      (e_dealloc_rs1),
    .e_valid      (e_valid),
    .all_ready    (all_ready_rs1),
    .src_state    (slot_state_s),
    .e_static     (e_static),
    .alloc_static (e_alloc_static_rs0),
    .wb_valid     (wb_valid_rb0),
    .wb_result    (wb_result_rb0)
  );

endmodule

// File: tb/tb_rs_src_trk.sv
// Directed plus randomized bench for rs_src_trk against a per-operand reference model.
module tb_rs_src_trk;
  import rs_defs::*;

  localparam int NS = 2;
  localparam int NW = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic e_alloc_rs0;
  t_rs_src_static [NS-1:0] e_alloc_static_rs0;
  logic [NS-1:0][DW-1:0] regrd_data_rs0;
  logic e_dealloc_rs1;
  logic [NW-1:0] wb_valid_rb0;
  t_wb_port [NW-1:0] wb_result_rb0;
  logic e_valid;
  t_rs_src_static [NS-1:0] e_static;
  logic [NS-1:0] src_ready_rs1;
  logic all_ready_rs1;
  logic [NS-1:0][DW-1:0] src_data;

  int checks = 0;
  int errors = 0;

  // reference model: an operand is either available (with value), waiting on an id, or absent
  bit             m_valid;
  bit             m_avail [NS];
  bit             m_waits [NS];
  logic [DW-1:0]  m_val   [NS];
  t_rs_src_static m_stat  [NS];

  rs_src_trk #(.NUM_SRCS(NS), .NUM_WB(NW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .e_alloc_rs0(e_alloc_rs0), .e_alloc_static_rs0(e_alloc_static_rs0),
    .regrd_data_rs0(regrd_data_rs0), .e_dealloc_rs1(e_dealloc_rs1),
    .wb_valid_rb0(wb_valid_rb0), .wb_result_rb0(wb_result_rb0),
    .e_valid(e_valid), .e_static(e_static), .src_ready_rs1(src_ready_rs1),
    .all_ready_rs1(all_ready_rs1), .src_data(src_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    for (int s = 0; s < NS; s++) begin
      m_avail[s] = 1'b0; m_waits[s] = 1'b0; m_val[s] = '0; m_stat[s] = '0;
    end
  endtask

  task automatic idle();
    flush = 1'b0; e_alloc_rs0 = 1'b0; e_dealloc_rs1 = 1'b0;
    e_alloc_static_rs0 = '0; regrd_data_rs0 = '0;
    wb_valid_rb0 = '0; wb_result_rb0 = '0;
  endtask

  task automatic set_src(input int s, input bit fr, input int id, input logic [DW-1:0] d);
    e_alloc_static_rs0[s] = '{from_rob: fr, robid: t_rob_id'(id), descr: t_uopnd_descr'(s + 1)};
    regrd_data_rs0[s] = d;
  endtask

  task automatic set_wb(input int p, input int id, input logic [DW-1:0] v);
    wb_valid_rb0[p] = 1'b1;
    wb_result_rb0[p] = '{robid: t_rob_id'(id), value: v};
  endtask

  task automatic check_all(input string tag);
    bit exp_all;
    exp_all = m_valid;
    chk({tag, ".e_valid"}, 64'(e_valid), 64'(m_valid));
    for (int s = 0; s < NS; s++) begin
      exp_all = exp_all & m_avail[s];
      chk($sformatf("%s.ready%0d", tag, s), 64'(src_ready_rs1[s]), 64'(m_avail[s]));
      chk($sformatf("%s.data%0d", tag, s), 64'(src_data[s]), 64'(m_val[s]));
      chk($sformatf("%s.static%0d", tag, s), 64'(e_static[s]), 64'(m_stat[s]));
    end
    chk({tag, ".all_ready"}, 64'(all_ready_rs1), 64'(exp_all));
  endtask

  // Advance one clock: derive the model's outcome from the driven events, then compare.
  task automatic tick(input string tag);
    bit fl, al, de;
    fl = flush;
    al = e_alloc_rs0 && !fl;
    de = e_dealloc_rs1 && !e_alloc_rs0 && !fl;
    for (int s = 0; s < NS; s++) begin
      t_rob_id want;
      bit hit;
      logic [DW-1:0] hv;
      want = al ? e_alloc_static_rs0[s].robid : m_stat[s].robid;
      hit = 1'b0; hv = '0;
      for (int p = 0; p < NW; p++)
        if (!hit && wb_valid_rb0[p] && wb_result_rb0[p].robid == want) begin
          hit = 1'b1; hv = wb_result_rb0[p].value;
        end
      if (fl) begin
        m_avail[s] = 1'b0; m_waits[s] = 1'b0;
      end else if (al) begin
        m_stat[s] = e_alloc_static_rs0[s];
        if (!e_alloc_static_rs0[s].from_rob) begin
          m_avail[s] = 1'b1; m_waits[s] = 1'b0; m_val[s] = regrd_data_rs0[s];
        end else if (hit) begin
          m_avail[s] = 1'b1; m_waits[s] = 1'b0; m_val[s] = hv;
        end else begin
          m_avail[s] = 1'b0; m_waits[s] = 1'b1;
        end
      end else if (de) begin
        m_avail[s] = 1'b0; m_waits[s] = 1'b0;
      end else if (m_waits[s] && hit) begin
        m_avail[s] = 1'b1; m_waits[s] = 1'b0; m_val[s] = hv;
      end
    end
    if (fl) m_valid = 1'b0;
    else if (al) m_valid = 1'b1;
    else if (de) m_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    reset = 1'b1;

    // 1: reset while a source waits on the ROB
    set_src(0, 1'b1, 9, 32'h0); set_src(1, 1'b0, 0, 32'h5);
    e_alloc_rs0 = 1'b1;
    tick("t1_alloc");
    idle();
    chk("t1_pending", 64'(src_ready_rs1), 64'b10);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_all("t1_async_rst");
    @(posedge clk); #1;
    check_all("t1_rst_edge");
    reset = 1'b1;
    set_src(0, 1'b0, 0, 32'h1234); set_src(1, 1'b0, 0, 32'h1234);
    e_alloc_rs0 = 1'b1;
    tick("t1_rf_alloc");
    idle();
    chk("t1_data", 64'(src_data[0]), 64'h1234);
    chk("t1_ready", 64'(src_ready_rs1), 64'b11);

    // 2: ROB wait resolved by port 1 three cycles later
    set_src(0, 1'b1, 5, 32'h0); set_src(1, 1'b0, 0, 32'hA);
    e_alloc_rs0 = 1'b1; e_dealloc_rs1 = 1'b1;
    tick("t2_alloc");
    idle();
    tick("t2_wait1");
    tick("t2_wait2");
    chk("t2_not_ready", 64'(all_ready_rs1), 64'd0);
    set_wb(1, 5, 32'hBEEF);
    tick("t2_wb");
    idle();
    chk("t2_all_ready", 64'(all_ready_rs1), 64'd1);
    chk("t2_data", 64'(src_data[0]), 64'hBEEF);

    // 3: alloc bypass from a same-cycle writeback
    set_src(0, 1'b1, 7, 32'h0); set_src(1, 1'b0, 0, 32'h55);
    e_alloc_rs0 = 1'b1; e_dealloc_rs1 = 1'b1;
    set_wb(0, 7, 32'h77);
    tick("t3_bypass");
    idle();
    chk("t3_data", 64'(src_data[0]), 64'h77);
    chk("t3_ready", 64'(src_ready_rs1[0]), 64'd1);

    // 6: duplicate writeback to a ready source is ignored
    set_wb(0, 7, 32'hDEAD);
    tick("t6_dup_wb");
    idle();
    chk("t6_data_kept", 64'(src_data[0]), 64'h77);

    // 4: non-matching writeback on both ports, then the matching one
    set_src(0, 1'b1, 3, 32'h0); set_src(1, 1'b0, 0, 32'h66);
    e_alloc_rs0 = 1'b1; e_dealloc_rs1 = 1'b1;
    tick("t4_alloc");
    idle();
    set_wb(0, 4, 32'h44); set_wb(1, 4, 32'h45);
    tick("t4_miss");
    idle();
    chk("t4_still_pending", 64'(src_ready_rs1[0]), 64'd0);
    set_wb(0, 3, 32'h333);
    tick("t4_hit");
    idle();
    chk("t4_data", 64'(src_data[0]), 64'h333);

    // 5: flush beats alloc; then alloc+dealloc reuses the entry
    flush = 1'b1; e_alloc_rs0 = 1'b1;
    set_src(0, 1'b0, 0, 32'h99); set_src(1, 1'b0, 0, 32'h98);
    tick("t5_flush_alloc");
    idle();
    chk("t5_flushed", 64'({e_valid, src_ready_rs1}), 64'd0);
    set_src(0, 1'b0, 0, 32'h11); set_src(1, 1'b0, 0, 32'h22);
    e_alloc_rs0 = 1'b1;
    tick("t5_alloc");
    idle();
    set_src(0, 1'b0, 0, 32'h33); set_src(1, 1'b0, 0, 32'h44);
    e_alloc_rs0 = 1'b1; e_dealloc_rs1 = 1'b1;
    tick("t5_reuse");
    idle();
    chk("t5_valid", 64'(e_valid), 64'd1);
    chk("t5_data1", 64'(src_data[1]), 64'h44);

    // randomized legal traffic
    for (int i = 0; i < 400; i++) begin
      bit all_rdy;
      int id0;
      idle();
      all_rdy = m_valid && m_avail[0] && m_avail[1];
      flush = ($urandom_range(19) == 0);
      e_dealloc_rs1 = all_rdy && ($urandom_range(1) == 1);
      e_alloc_rs0 = (!m_valid || e_dealloc_rs1) && ($urandom_range(2) != 0);
      for (int s = 0; s < NS; s++)
        set_src(s, 1'($urandom_range(1)), int'($urandom_range(7)), $urandom);
      id0 = int'($urandom_range(7));
      if ($urandom_range(1) == 1) set_wb(0, id0, $urandom);
      if ($urandom_range(1) == 1) set_wb(1, (id0 + 1 + int'($urandom_range(6))) % 8, $urandom);
      tick($sformatf("rnd%0d", i));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
